// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller.
// Optional ack timeout is enabled by defining IRQ_TIMEOUT_EN.
package irq_pkg;
  localparam int N_IRQ_DEF   = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  function automatic int vec_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/irq_controller_if.sv
// CPU-side interrupt handshake: request/vector out, ack/eoi back in.
interface irq_controller_if #(parameter int N_IRQ = irq_pkg::N_IRQ_DEF);
  import irq_pkg::*;
  localparam int VW = vec_w(N_IRQ);

  logic          int_req;
  logic          intd;
  logic          nmi;
  logic [VW-1:0] vector;
  logic          in_service;
  logic          timeout_flag;
  logic          int_ack;
  logic          eoi;

  modport master (output int_req, intd, nmi, vector, in_service, timeout_flag,
                  input  int_ack, eoi);
  modport slave  (input  int_req, intd, nmi, vector, in_service, timeout_flag,
                  output int_ack, eoi);
endinterface

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest set bit wins.
module irq_priority_encoder #(
  parameter int N  = 8,
  parameter int VW = 3
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [VW-1:0] index
);
  always_comb begin
    valid = |req;
    index = '0;
    // Scan high to low so the lowest index overwrites last.
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) index = VW'(i);
  end
endmodule

// File: rtl/irq_controller.sv
// Edge-detecting, masked, fixed-priority IRQ source for the CPU handshake.
// Define IRQ_TIMEOUT_EN to abandon an unacknowledged request after TIMEOUT cycles.
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ   = N_IRQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             nmi_src,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  irq_controller_if.master cpu
);
  localparam int VW = vec_w(N_IRQ);

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] irq_q, pending_q, pending_d, mask_q, mask_d, clr;
  logic [VW-1:0]    vector_q, vector_d;
  logic             nmi_src_q, nmi_q, nmi_d;
  logic             int_req_q, intd_q, tflag_q, tflag_d;
  logic             pe_valid;
  logic [VW-1:0]    pe_index;

  irq_priority_encoder #(.N(N_IRQ), .VW(VW)) u_pe (
    .req   (pending_q & ~mask_q),
    .valid (pe_valid),
    .index (pe_index)
  );

`ifdef IRQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    tflag_d  = tflag_q;
    clr      = '0;
`ifdef IRQ_TIMEOUT_EN
    cnt_d    = '0;
`endif
    case (state_q)
      IDLE: if (pe_valid) begin
        vector_d = pe_index;
        state_d  = REQ;
      end
      REQ: begin
        // A same-cycle eoi is dropped; only the ack is acted on.
        if (cpu.int_ack) begin
          clr[vector_q] = 1'b1;
          state_d       = SERVICE;
        end
`ifdef IRQ_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          tflag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      SERVICE: if (cpu.eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // New edge beats a same-cycle ack clear.
    pending_d = (pending_q & ~clr) | (irq & ~irq_q);
    mask_d    = mask_we ? mask_wdata : mask_q;
    nmi_d     = nmi_q | (nmi_src & ~nmi_src_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      vector_q  <= '0;
      nmi_src_q <= 1'b0;
      nmi_q     <= 1'b0;
      int_req_q <= 1'b0;
      intd_q    <= 1'b0;
      tflag_q   <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      irq_q     <= irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      vector_q  <= vector_d;
      nmi_src_q <= nmi_src;
      nmi_q     <= nmi_d;
      int_req_q <= (state_d == REQ);
      intd_q    <= (state_d == SERVICE);
      tflag_q   <= tflag_d;
`ifdef IRQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign cpu.int_req      = int_req_q;
  assign cpu.intd         = intd_q;
  assign cpu.in_service   = intd_q;
  assign cpu.nmi          = nmi_q;
  assign cpu.vector       = vector_q;
  assign cpu.timeout_flag = tflag_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed table-driven bench for irq_controller plus reset/mask and timeout sequences.
module tb_irq_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq;
  logic       nmi_src, mask_we;
  logic [7:0] mask_wdata;
  int         n_tests = 0, n_fail = 0;

  irq_controller_if #(.N_IRQ(8)) cpu_if ();

  irq_controller #(.N_IRQ(8), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .nmi_src    (nmi_src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .cpu        (cpu_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq;
    logic       mwe;
    logic [7:0] mw;
    logic       ack, eoi, nsrc;
    logic       e_req, e_intd;
    logic [2:0] e_vec;
    logic       e_nmi, chk_nmi;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] i, logic we, logic [7:0] w, logic a, logic e,
                              logic n, logic r, logic d, logic [2:0] v, logic en, logic cn);
    vec_t t;
    t.irq = i; t.mwe = we; t.mw = w; t.ack = a; t.eoi = e; t.nsrc = n;
    t.e_req = r; t.e_intd = d; t.e_vec = v; t.e_nmi = en; t.chk_nmi = cn;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req"},  32'(cpu_if.int_req), 0);
    check({tag, ".intd"}, 32'(cpu_if.intd), 0);
    check({tag, ".isv"},  32'(cpu_if.in_service), 0);
    check({tag, ".nmi"},  32'(cpu_if.nmi), 0);
    check({tag, ".vec"},  32'(cpu_if.vector), 0);
    check({tag, ".tf"},   32'(cpu_if.timeout_flag), 0);
  endtask

  initial begin
    reset = 1'b1; irq = '0; nmi_src = 0; mask_we = 0; mask_wdata = '0;
    cpu_if.int_ack = 0; cpu_if.eoi = 0;

    //            irq    we  mw    ack eoi nsrc req intd vec nmi chk
    tbl.push_back(mk(8'h00, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 3, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 3, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 3, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 3, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    // irq[5] and irq[2] together
    tbl.push_back(mk(8'h24, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 2, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 2, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 5, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 5, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 5, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1));
    // masked source, then unmask
    tbl.push_back(mk(8'h00, 1, 8'h08, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h00, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 3, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 3, 0, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1));
    // held level on irq[4], higher-priority irq[1] arrives during REQ, NMI mid-service
    tbl.push_back(mk(8'h10, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(8'h10, 0, 8'h00, 0, 0, 0, 1, 0, 4, 0, 1));
    tbl.push_back(mk(8'h12, 0, 8'h00, 0, 0, 0, 1, 0, 4, 0, 1));
    tbl.push_back(mk(8'h10, 0, 8'h00, 0, 0, 0, 1, 0, 4, 0, 1));
    tbl.push_back(mk(8'h10, 0, 8'h00, 1, 0, 0, 0, 1, 4, 0, 1));
    tbl.push_back(mk(8'h10, 0, 8'h00, 0, 0, 1, 0, 1, 4, 0, 0));
    tbl.push_back(mk(8'h10, 0, 8'h00, 0, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(8'h10, 0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 1));

    tick(); tick();
    check_all_zero("rst");
    reset = 1'b0;

    foreach (tbl[i]) begin
      irq = tbl[i].irq; mask_we = tbl[i].mwe; mask_wdata = tbl[i].mw;
      cpu_if.int_ack = tbl[i].ack; cpu_if.eoi = tbl[i].eoi; nmi_src = tbl[i].nsrc;
      tick();
      check($sformatf("s%0d.req", i),  32'(cpu_if.int_req), 32'(tbl[i].e_req));
      check($sformatf("s%0d.intd", i), 32'(cpu_if.intd), 32'(tbl[i].e_intd));
      check($sformatf("s%0d.isv", i),  32'(cpu_if.in_service), 32'(tbl[i].e_intd));
      check($sformatf("s%0d.tf", i),   32'(cpu_if.timeout_flag), 0);
      if (tbl[i].e_req || tbl[i].e_intd)
        check($sformatf("s%0d.vec", i), 32'(cpu_if.vector), 32'(tbl[i].e_vec));
      if (tbl[i].chk_nmi)
        check($sformatf("s%0d.nmi", i), 32'(cpu_if.nmi), 32'(tbl[i].e_nmi));
    end
    mask_we = 0; cpu_if.int_ack = 0; cpu_if.eoi = 0; nmi_src = 0; irq = '0;

    // Reset while requesting: everything clears, mask back to all ones.
    reset = 1'b1; tick();
    check_all_zero("mid_rst");
    reset = 1'b0;
    irq = 8'h01; tick();
    irq = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("masked%0d.req", k), 32'(cpu_if.int_req), 0);
    end
    mask_we = 1; mask_wdata = 8'h00; tick();
    mask_we = 0;
    check("unmask0.req", 32'(cpu_if.int_req), 0);
    tick();
    check("unmask1.req", 32'(cpu_if.int_req), 1);
    check("unmask1.vec", 32'(cpu_if.vector), 0);
    cpu_if.int_ack = 1; tick(); cpu_if.int_ack = 0;
    cpu_if.eoi = 1; tick(); cpu_if.eoi = 0;
    check("rel.intd", 32'(cpu_if.intd), 0);

`ifdef IRQ_TIMEOUT_EN
    begin
      int hi;
      bit seen;
      hi = 0; seen = 0;
      irq = 8'h40; tick(); irq = 8'h00;
      for (int k = 0; k < 20 && !seen; k++) begin
        tick();
        if (cpu_if.int_req) seen = 1;
      end
      check("to.seen", 32'(seen), 1);
      while (cpu_if.int_req && hi < 20) begin
        hi++;
        tick();
      end
      check("to.hi_cycles", 32'(hi), 4);
      check("to.drop", 32'(cpu_if.int_req), 0);
      check("to.flag", 32'(cpu_if.timeout_flag), 1);
      tick();
      check("to.rereq", 32'(cpu_if.int_req), 1);
      check("to.vec", 32'(cpu_if.vector), 6);
      check("to.flag_sticky", 32'(cpu_if.timeout_flag), 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
